// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the F-stage PC and runs a req/rdy handshake to instruction memory.
// It applies D-stage redirects with delay-slot semantics and uses a one-entry skid buffer under stall.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc8
);

    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        discard_q, discard_d;

    logic        consume;
    logic        complete;
    logic        accept;
    logic        flush;
    logic        keep_data;
    logic [31:0] pc_redir;
    logic        pend_valid_redir;
    logic [31:0] pend_target_redir;

    always_comb begin
        consume   = out_valid_q && !stall;
        complete  = req_q && imem_rdy;
        accept    = redir_valid && !stall;
        // Redirect with a valid output: that output is the delay slot, everything younger dies.
        flush     = accept && out_valid_q;
        keep_data = complete && !discard_q && !flush;

        pc_redir          = pc_q;
        pend_valid_redir  = pend_valid_q;
        pend_target_redir = pend_target_q;
        if (accept) begin
            if (out_valid_q) begin
                pc_redir         = redir_target;
                pend_valid_redir = 1'b0;
            end else if (req_q && !discard_q) begin
                // The live outstanding request is the delay slot itself.
                pc_redir = redir_target;
            end else begin
                pend_valid_redir  = 1'b1;
                pend_target_redir = redir_target;
            end
        end

        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end
        if (consume) begin
            if (skid_valid_d) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (keep_data) begin
                out_valid_d = 1'b1;
                out_pc_d    = addr_q;
                out_instr_d = imem_rdata;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (keep_data) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = addr_q;
                out_instr_d = imem_rdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = addr_q;
                skid_instr_d = imem_rdata;
            end
        end

        discard_d = discard_q;
        if (complete) begin
            discard_d = 1'b0;
        end
        if (flush && req_q && !complete) begin
            discard_d = 1'b1;
        end

        req_d         = req_q;
        addr_d        = addr_q;
        pc_d          = pc_redir;
        pend_valid_d  = pend_valid_redir;
        pend_target_d = pend_target_redir;
        if (!req_q || complete) begin
            if (!skid_valid_d) begin
                req_d  = 1'b1;
                addr_d = pc_redir;
                if (pend_valid_redir) begin
                    // This launch is the delay slot; the one after it goes to the target.
                    pc_d         = pend_target_redir;
                    pend_valid_d = 1'b0;
                end else begin
                    pc_d = pc_redir + 32'd4;
                end
            end else begin
                req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            addr_q        <= 32'd0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_instr_q   <= 32'd0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= 32'd0;
            skid_instr_q  <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            discard_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            discard_q     <= discard_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = out_valid_q;
    assign if_pc     = out_pc_q;
    assign if_instr  = out_instr_q;
    assign if_pc8    = out_pc_q + 32'd8;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer for the 5-stage MIPS pipeline. Owns the F-stage PC register and drives a request/ready handshake to instruction memory with variable latency. Applies D-stage branch/jump redirects with correct delay-slot semantics, and honours hazard-unit stalls through a one-entry skid buffer. Delivers {valid, pc, instr} to the F/D pipeline register.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: D stage does not consume the F output this cycle
redir_valid  in  1  D stage resolved a taken branch/jump this cycle
redir_target  in  32  redirect target address, word-aligned
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch address, registered, stable while imem_req is high
imem_rdy  in  1  memory completes the transaction this cycle
imem_rdata  in  32  instruction word, valid when imem_req && imem_rdy
if_valid  out  1  F output holds an instruction
if_pc  out  32  address of the F output instruction
if_instr  out  32  F output instruction
if_pc8  out  32  if_pc + 8 (link address), combinational

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC; imem_req=0; imem_addr=0; if_valid=0; if_pc=0; if_instr=0; skid_valid=0; pend_valid=0; discard=0. Reset mid-transaction abandons the outstanding request. The memory must tolerate req dropping without rdy.
- Consume: the output is taken on cycles with if_valid && !stall. The slot is then free unless refilled in the same cycle.
- Handshake: once imem_req is high, it and imem_addr hold until the cycle with imem_rdy=1. A transaction completes on imem_req && imem_rdy.
- Launch: a request is issued (imem_req<=1, imem_addr<=pc, pc<=pc+4) when no request is outstanding (or one completes this cycle) and skid_valid=0 after the cycle's updates.
  - After reset, the first request is visible the cycle after reset falls, with addr=RESET_PC.
  - Back-to-back requests are allowed, so the minimum interval is one cycle with rdy tied high.
- Response routing at completion, with discard=0:
  - If the slot is free or being consumed, the data loads the output next cycle (if_valid=1, if_pc=imem_addr).
  - Otherwise the data goes to the skid buffer.
- Skid buffer: when the output is consumed and skid_valid=1, the skid entry moves to the output with priority over a memory response. No new launch occurs while skid_valid=1.
- Discard: if discard=1 at completion, the data is dropped, discard clears, and launch proceeds normally.
- Redirects are accepted only on redir_valid && !stall. redir_valid is ignored while stall=1; the D stage re-presents it.
- Redirect, case A (if_valid=1 at accept): the output is the delay slot and is consumed normally.
  - Flush skid_valid.
  - If a request is outstanding and not completing this cycle, set discard=1.
  - If a request is completing this cycle, drop its data.
  - Set pc<=redir_target. The next launch uses redir_target.
- Redirect, case B (if_valid=0 at accept): the next delivered instruction is the delay slot.
  - Set pend_valid=1 and pend_target=redir_target.
  - When the delay-slot request is launched, pc<=pend_target instead of pc+4, and pend_valid clears.
  - If the delay-slot request is already outstanding, pc<=pend_target immediately.
- Priority within a cycle: reset > redirect accept > response routing > launch. Redirect accept and completion in the same cycle follow the case A/B rules above.
- Arithmetic: pc+4 and if_pc+8 wrap modulo 2^32. No alignment checking.

Test Plan:
1. Reset, rdy tied 1, no stall -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_valid=1 from cycle 2 on, if_pc tracks one cycle behind; if_pc8=0x3008 when if_pc=0x3000.
2. 3-cycle memory latency, stall=0 -> req/addr held stable 3 cycles per fetch; if_valid pulses one cycle per completion; no address skipped.
3. stall raised for 4 cycles while a request is outstanding -> response goes to skid, no new launch, if_pc/if_instr frozen; on stall fall the skid entry is delivered, then the next address; no duplicate or lost instruction.
4. Redirect case A: branch at 0x3010 in D, if_pc=0x3014 valid, 0x3018 outstanding, target 0x3100 -> 0x3014 delivered; 0x3018 response dropped; next delivered if_pc=0x3100.
5. Redirect case B: if_valid=0, delay slot 0x3014 outstanding with 2-cycle latency, target 0x3200 -> 0x3014 delivered, then 0x3200; address 0x3018 never requested.
6. redir_valid asserted with stall=1 -> ignored, pc unchanged; reset asserted mid-transaction -> next cycle imem_req=0, if_valid=0, and fetch restarts at 0x3000.
